ofm_writeback_packer: RTL
=========================

# ofm_writeback_packer

Packs the per-cycle OFM bytes produced by the fused block's 1x1 PE cluster (four PEs, one byte each per valid cycle) into 128-bit words. Writes them sequentially into the global BRAM starting at a programmable base address. Sits directly downstream of the PE cluster and upstream of the global BRAM write port. It replaces the bench-side OFM file dump with an in-fabric write-back path, so a following fused block can read layer-2 OFM from global memory.

## Interface
Parameters:
- NUM_PE, 4: PEs in the cluster; bytes per beat.
- DATA_W, 128: global BRAM word width; beats per word = DATA_W/(8*NUM_PE) = 4.
- ADDR_W, 32: global BRAM word-address width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches base/size and begins a job (ignored unless IDLE).
- base_addr_OFM  in  ADDR_W  first word address written.
- size_OFM  in  32  job length in 128-bit words.
- pe_valid  in  NUM_PE  per-PE byte-valid (PE_finish); a beat is 4'hF.
- ofm_in  in  8*NUM_PE  byte k = PE k output.
- ofm_ready  out  1  beat is accepted this cycle when pe_valid==4'hF && ofm_ready.
- wr_addr_global  out  ADDR_W  write address.
- data_out_global  out  DATA_W  write data.
- we_global  out  1  write request; the write completes on a cycle with we_global && wr_ready.
- wr_ready  in  1  BRAM port grant.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky protocol error (see Configuration).

## Operation
- State machine with states IDLE, RUN, DRAIN, DONE.
  - IDLE:
    - start with size_OFM!=0 -> RUN.
    - start with size_OFM==0 -> DONE.
  - RUN: accept beats until words_packed==size -> DRAIN.
  - DRAIN: wait until FIFO empty -> DONE.
  - DONE: lasts one cycle, done=1 -> IDLE.
- Packing:
  - Beat index j (0..3) places PE k's byte at data bits [8*(4j+k)+7 : 8*(4j+k)].
  - The first beat goes to the low bytes.
  - The 4th beat pushes the assembled word into a 2-entry word FIFO, and words_packed is incremented.
- ofm_ready = (state==RUN) && !fifo_full && (words_packed < size).
- Output side:
  - we_global = FIFO not empty.
  - data_out_global = FIFO head.
  - wr_addr_global = base + words_written.
  - A write that completes pops the FIFO and increments words_written.
- Widths: counters are 32 bits. The address adds modulo 2^ADDR_W; wrap is permitted, not flagged.
- Simultaneous push and pop while FIFO full is impossible because ofm_ready is low. Simultaneous push and pop at occupancy 1 keeps occupancy at 1.
- start while not IDLE: ignored, no effect on counters.
- reset mid-job: everything returns to reset values next edge; FIFO contents and the partial word are discarded; done is not pulsed.
- Reset values: ofm_ready=0, we_global=0, wr_addr_global=0, data_out_global=0, busy=0, done=0, err=0. All counters and beat index are 0.

## Timing
- Latency: 4th beat accepted at edge t -> we_global=1 during cycle t+1 (assuming FIFO was empty).
- Throughput: one beat per cycle sustained while wr_ready stays high; one word write every 4 cycles.
- done asserts the cycle after the last write completes: last write at edge t -> DONE during cycle t+1.
- busy deasserts in the same cycle done is high.
- we_global must hold, with address and data stable, until wr_ready is sampled high.

## Configuration
- OFM_WB_ERR_CHECK_EN defined:
  - In RUN, a cycle with pe_valid nonzero but not 4'hF sets err (sticky until reset or next start) and discards that beat.
  - A full beat arriving while ofm_ready=0 also sets err.
- OFM_WB_ERR_CHECK_EN undefined:
  - err is tied 0.
  - Partial pe_valid and unaccepted beats are silently ignored.

## Structure
- Package ofm_wb_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - localparams DATA_W, NUM_PE, BEATS_PER_WORD;
  - the byte-lane index function.
- Sub-module ofm_wb_fifo: 2-entry, DATA_W-wide, synchronous FIFO with push/pop/full/empty. It uses the same clk and reset.

## Test plan
- Basic job:
  - Stimulus: base=0x33C00, size=2; 8 full beats with bytes 0x00..0x1F in PE order; wr_ready=1.
  - Response: writes 0x33C00 = 0x0F0E..0100 and 0x33C01 = 0x1F1E..1110; done pulses once, 1 cycle after the 2nd write.
- Backpressure:
  - Stimulus: size=4, continuous beats, wr_ready low for 10 cycles.
  - Response: ofm_ready drops once the FIFO holds 2 words; no beat lost; 4 writes total, in order.
- Zero size:
  - Stimulus: start with size=0.
  - Response: done high in cycle 1 after start; we_global never asserts.
- Reset mid-job:
  - Stimulus: reset after 6 beats of a size=3 job.
  - Response: all outputs return to reset values next edge; no done pulse; a new job restarts at its base with beat index 0.
- Error check (OFM_WB_ERR_CHECK_EN):
  - Stimulus: pe_valid=4'b0111 mid-job.
  - Response: err=1, beat discarded, word content unchanged. The same stimulus without the macro leaves err=0.
- Address wrap:
  - Stimulus: base=0xFFFFFFFF, size=2.
  - Response: writes to 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/ofm_wb_pkg.sv
// Shared types and helpers for the OFM write-back packer.
package ofm_wb_pkg;
  localparam int NUM_PE         = 4;
  localparam int DATA_W         = 128;
  localparam int BEATS_PER_WORD = DATA_W / (8 * NUM_PE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // Byte position inside the packed word for PE `pe` on beat `beat`.
  // The first beat lands in the low bytes.
  function automatic int lane_byte(input int beat, input int pe, input int num_pe);
    return beat * num_pe + pe;
  endfunction
endpackage

// File: rtl/ofm_wb_fifo.sv
// 2-entry word FIFO between the packer and the global BRAM write port.
// Push while full and pop while empty are ignored.
module ofm_wb_fifo #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              do_push, do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; push+pop at occupancy 1 holds it at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ofm_writeback_packer.sv
// Packs per-cycle PE-cluster OFM bytes into DATA_W words and writes them to
// consecutive global BRAM addresses starting at a programmable base.
// Optional macro OFM_WB_ERR_CHECK_EN enables the sticky protocol-error flag;
// without it err is tied low and malformed beats are silently dropped.
module ofm_writeback_packer #(
  parameter int NUM_PE = 4,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr_OFM,
  input  logic [31:0]         size_OFM,
  input  logic [NUM_PE-1:0]   pe_valid,
  input  logic [8*NUM_PE-1:0] ofm_in,
  output logic                ofm_ready,
  output logic [ADDR_W-1:0]   wr_addr_global,
  output logic [DATA_W-1:0]   data_out_global,
  output logic                we_global,
  input  logic                wr_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);
  import ofm_wb_pkg::*;

  localparam int BPW = DATA_W / (8 * NUM_PE);
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

  state_e            state;
  logic [ADDR_W-1:0] base;
  logic [31:0]       size, words_packed, words_written;
  logic [BIW-1:0]    beat_idx;
  logic [DATA_W-1:0] word_buf, next_word;
  logic              fifo_full, fifo_empty;
  logic              full_beat, accept, last_beat, push, wr_done, last_write;

  assign full_beat  = &pe_valid;
  assign ofm_ready  = (state == RUN) && !fifo_full && (words_packed < size);
  assign accept     = full_beat && ofm_ready;
  assign last_beat  = (beat_idx == BIW'(BPW - 1));
  assign push       = accept && last_beat;
  assign we_global  = !fifo_empty;
  assign wr_done    = we_global && wr_ready;
  // The write completing now is the job's last one: go straight to DONE so
  // done lands in the cycle right after it.
  assign last_write = wr_done && ((words_written + 32'd1) == size);
  assign wr_addr_global = base + ADDR_W'(words_written);
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  // Merge the current beat into the partial word; on the last beat this is
  // the complete word handed to the FIFO.
  always_comb begin
    next_word = word_buf;
    for (int k = 0; k < NUM_PE; k++)
      next_word[8*lane_byte(int'(beat_idx), k, NUM_PE) +: 8] = ofm_in[8*k +: 8];
  end

  ofm_wb_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (next_word),
    .pop   (wr_done),
    .dout  (data_out_global),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Job FSM with beat packing and word/write counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      base          <= '0;
      size          <= '0;
      words_packed  <= '0;
      words_written <= '0;
      beat_idx      <= '0;
      word_buf      <= '0;
    end else begin
      if (wr_done) words_written <= words_written + 32'd1;
      case (state)
        IDLE: if (start) begin
          base          <= base_addr_OFM;
          size          <= size_OFM;
          words_packed  <= '0;
          words_written <= '0;
          beat_idx      <= '0;
          word_buf      <= '0;
          state         <= (size_OFM == 32'd0) ? DONE : RUN;
        end
        RUN: begin
          if (accept) begin
            if (last_beat) begin
              beat_idx     <= '0;
              word_buf     <= '0;
              words_packed <= words_packed + 32'd1;
            end else begin
              beat_idx <= beat_idx + BIW'(1);
              word_buf <= next_word;
            end
          end
          if (last_write)                 state <= DONE;
          else if (words_packed == size)  state <= DRAIN;
        end
        DRAIN: if (fifo_empty || last_write) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OFM_WB_ERR_CHECK_EN
  logic err_q;
  // Sticky flag for partial pe_valid or a full beat offered while not ready.
  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (state == IDLE && start)
      err_q <= 1'b0;
    else if (state == RUN && (((|pe_valid) && !full_beat) || (full_beat && !ofm_ready)))
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule
